// File: rtl/logic_axi4_stream_downsizer_pkg.sv
// Shared types and elaboration helpers for the AXI4-Stream downsizer.
// Optional build macro consumed by users of this package: LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN.
package logic_axi4_stream_downsizer_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ds_state_e;

   // Upper bound on segments per wide beat handled by last_nonnull_seg().
   localparam int unsigned MAX_RATIO = 64;

   function automatic int unsigned ratio(input int unsigned rx_bytes, input int unsigned tx_bytes);
      return rx_bytes / tx_bytes;
   endfunction

   function automatic int unsigned index_width(input int unsigned r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

   // Highest segment below r whose non-null flag is set; 0 when none are set.
   function automatic int unsigned last_nonnull_seg(input logic [MAX_RATIO-1:0] seg_nz,
                                                    input int unsigned        r);
      int unsigned hi;
      hi = 0;
      for (int unsigned i = 0; i < MAX_RATIO; i++) begin
         if ((i < r) && seg_nz[i]) hi = i;
      end
      return hi;
   endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle with receiver (rx) and transmitter (tx) views.
interface logic_axi4_stream_if #(
   parameter int unsigned TDATA_BYTES = 1,
   parameter int unsigned TUSER_WIDTH = 1,
   parameter int unsigned TDEST_WIDTH = 1,
   parameter int unsigned TID_WIDTH   = 1
);
   logic                     tvalid;
   logic                     tready;
   logic [TDATA_BYTES*8-1:0] tdata;
   logic [TDATA_BYTES-1:0]   tkeep;
   logic [TDATA_BYTES-1:0]   tstrb;
   logic                     tlast;
   logic [TUSER_WIDTH-1:0]   tuser;
   logic [TDEST_WIDTH-1:0]   tdest;
   logic [TID_WIDTH-1:0]     tid;

   modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
   modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_downsizer_main.sv
// Downsizer datapath: holds one wide beat and walks it out as narrow segments, LSB first.
// Build macro LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN trims trailing all-null segments.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EMPTY | holding register free, rx.tready high once out of reset
//   ST_FULL  | segment r_idx of the held beat is presented on tx
module logic_axi4_stream_downsizer_main
   import logic_axi4_stream_downsizer_pkg::*;
#(
   parameter int unsigned RX_TDATA_BYTES = 4,
   parameter int unsigned TX_TDATA_BYTES = 1,
   parameter int unsigned RX_TUSER_WIDTH = 4,
   parameter int unsigned TX_TUSER_WIDTH = 1,
   parameter int unsigned TDEST_WIDTH    = 1,
   parameter int unsigned TID_WIDTH      = 1,
   parameter int unsigned USE_TLAST      = 1,
   parameter int unsigned USE_TKEEP      = 1,
   parameter int unsigned USE_TSTRB      = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_rx_tvalid,
   output logic                        o_rx_tready,
   input  logic [RX_TDATA_BYTES*8-1:0] i_rx_tdata,
   input  logic [RX_TDATA_BYTES-1:0]   i_rx_tkeep,
   input  logic [RX_TDATA_BYTES-1:0]   i_rx_tstrb,
   input  logic                        i_rx_tlast,
   input  logic [RX_TUSER_WIDTH-1:0]   i_rx_tuser,
   input  logic [TDEST_WIDTH-1:0]      i_rx_tdest,
   input  logic [TID_WIDTH-1:0]        i_rx_tid,
   output logic                        o_tx_tvalid,
   input  logic                        i_tx_tready,
   output logic [TX_TDATA_BYTES*8-1:0] o_tx_tdata,
   output logic [TX_TDATA_BYTES-1:0]   o_tx_tkeep,
   output logic [TX_TDATA_BYTES-1:0]   o_tx_tstrb,
   output logic                        o_tx_tlast,
   output logic [TX_TUSER_WIDTH-1:0]   o_tx_tuser,
   output logic [TDEST_WIDTH-1:0]      o_tx_tdest,
   output logic [TID_WIDTH-1:0]        o_tx_tid
);
   localparam int unsigned RATIO     = ratio(RX_TDATA_BYTES, TX_TDATA_BYTES);
   localparam int unsigned IW        = index_width(RATIO);
   localparam int unsigned TXW       = TX_TDATA_BYTES * 8;
   localparam logic [IW-1:0] LAST_FULL = IW'(RATIO - 1);

   ds_state_e                   r_state;
   logic                        r_rdy_en;
   logic [IW-1:0]               r_idx;
   logic [IW-1:0]               r_last_idx;
   logic [RX_TDATA_BYTES*8-1:0] r_data;
   logic [RX_TDATA_BYTES-1:0]   r_keep;
   logic [RX_TDATA_BYTES-1:0]   r_strb;
   logic                        r_tlast;
   logic [RX_TUSER_WIDTH-1:0]   r_user;
   logic [TDEST_WIDTH-1:0]      r_dest;
   logic [TID_WIDTH-1:0]        r_id;

   logic                        w_rx_fire;
   logic                        w_tx_fire;
   logic                        w_at_last;
   logic [IW-1:0]               w_cap_last_idx;

   assign w_at_last   = (r_idx == r_last_idx);
   assign o_rx_tready = r_rdy_en & ((r_state == ST_EMPTY) | (i_tx_tready & w_at_last));
   assign w_rx_fire   = i_rx_tvalid & o_rx_tready;
   assign w_tx_fire   = (r_state == ST_FULL) & i_tx_tready;

`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
   logic [MAX_RATIO-1:0] w_seg_nz;

   always_comb begin
      w_seg_nz = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
         w_seg_nz[i] = |i_rx_tkeep[i*TX_TDATA_BYTES +: TX_TDATA_BYTES];
      end
   end

   if (USE_TKEEP != 0) begin : g_skip_null
      assign w_cap_last_idx = IW'(last_nonnull_seg(w_seg_nz, RATIO));
   end else begin : g_full_len
      assign w_cap_last_idx = LAST_FULL;
   end
`else
   assign w_cap_last_idx = LAST_FULL;
`endif

   // r_rdy_en keeps rx.tready low until one cycle after the synchronized reset lifts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_EMPTY;
         r_idx      <= '0;
         r_last_idx <= '0;
         r_rdy_en   <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (r_state == ST_EMPTY) begin
            if (w_rx_fire) begin
               r_state    <= ST_FULL;
               r_idx      <= '0;
               r_last_idx <= w_cap_last_idx;
            end
         end else if (w_tx_fire) begin
            if (w_at_last) begin
               r_idx <= '0;
               if (w_rx_fire) r_last_idx <= w_cap_last_idx;
               else           r_state    <= ST_EMPTY;
            end else begin
               r_idx <= r_idx + IW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_rx_fire) begin
         r_data  <= i_rx_tdata;
         r_keep  <= i_rx_tkeep;
         r_strb  <= i_rx_tstrb;
         r_tlast <= i_rx_tlast;
         r_user  <= i_rx_tuser;
         r_dest  <= i_rx_tdest;
         r_id    <= i_rx_tid;
      end
   end

   assign o_tx_tvalid = (r_state == ST_FULL);
   assign o_tx_tdata  = r_data[r_idx*TXW +: TXW];
   assign o_tx_tuser  = r_user[r_idx*TX_TUSER_WIDTH +: TX_TUSER_WIDTH];
   assign o_tx_tdest  = r_dest;
   assign o_tx_tid    = r_id;
   assign o_tx_tlast  = (USE_TLAST != 0) ? (r_tlast & w_at_last) : 1'b0;

   if (USE_TKEEP != 0) begin : g_keep
      assign o_tx_tkeep = r_keep[r_idx*TX_TDATA_BYTES +: TX_TDATA_BYTES];
   end else begin : g_no_keep
      assign o_tx_tkeep = '1;
   end

   if (USE_TSTRB != 0) begin : g_strb
      assign o_tx_tstrb = r_strb[r_idx*TX_TDATA_BYTES +: TX_TDATA_BYTES];
   end else begin : g_no_strb
      assign o_tx_tstrb = '1;
   end
endmodule

// File: rtl/logic_reset_synchronizer.sv
// Active-low reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module logic_reset_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_rst_n
);
   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[STAGES-2:0], 1'b1};
   end

   assign o_rst_n = r_sync[STAGES-1];
endmodule

// File: rtl/logic_axi4_stream_downsizer.sv
// Wide-to-narrow AXI4-Stream converter: reset synchronizer plus downsizer datapath.
// Build macro LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN drops trailing null segments.
module logic_axi4_stream_downsizer #(
   parameter int unsigned RX_TDATA_BYTES = 4,
   parameter int unsigned TX_TDATA_BYTES = 1,
   parameter int unsigned RX_TUSER_WIDTH = 4,
   parameter int unsigned TX_TUSER_WIDTH = 1,
   parameter int unsigned TDEST_WIDTH    = 1,
   parameter int unsigned TID_WIDTH      = 1,
   parameter int unsigned USE_TLAST      = 1,
   parameter int unsigned USE_TKEEP      = 1,
   parameter int unsigned USE_TSTRB      = 1
) (
   input  logic             aclk,
   input  logic             areset_n,
   logic_axi4_stream_if.rx  rx,
   logic_axi4_stream_if.tx  tx
);
   logic w_rst_n;

   logic_reset_synchronizer #(.STAGES(2)) u_rst_sync (
      .i_clk   (aclk),
      .i_rst_n (areset_n),
      .o_rst_n (w_rst_n)
   );

   logic_axi4_stream_downsizer_main #(
      .RX_TDATA_BYTES (RX_TDATA_BYTES),
      .TX_TDATA_BYTES (TX_TDATA_BYTES),
      .RX_TUSER_WIDTH (RX_TUSER_WIDTH),
      .TX_TUSER_WIDTH (TX_TUSER_WIDTH),
      .TDEST_WIDTH    (TDEST_WIDTH),
      .TID_WIDTH      (TID_WIDTH),
      .USE_TLAST      (USE_TLAST),
      .USE_TKEEP      (USE_TKEEP),
      .USE_TSTRB      (USE_TSTRB)
   ) u_main (
      .i_clk       (aclk),
      .i_rst_n     (w_rst_n),
      .i_rx_tvalid (rx.tvalid),
      .o_rx_tready (rx.tready),
      .i_rx_tdata  (rx.tdata),
      .i_rx_tkeep  (rx.tkeep),
      .i_rx_tstrb  (rx.tstrb),
      .i_rx_tlast  (rx.tlast),
      .i_rx_tuser  (rx.tuser),
      .i_rx_tdest  (rx.tdest),
      .i_rx_tid    (rx.tid),
      .o_tx_tvalid (tx.tvalid),
      .i_tx_tready (tx.tready),
      .o_tx_tdata  (tx.tdata),
      .o_tx_tkeep  (tx.tkeep),
      .o_tx_tstrb  (tx.tstrb),
      .o_tx_tlast  (tx.tlast),
      .o_tx_tuser  (tx.tuser),
      .o_tx_tdest  (tx.tdest),
      .o_tx_tid    (tx.tid)
   );
endmodule
